// File: rtl/odo_sbox_bank.sv
// odo_sbox_bank: runtime-loadable S-box table shared by LANES lookup lanes.
// Sequential table load, then fixed-latency parallel lookups.
module odo_sbox_bank #(
  parameter int IN_W    = 6,
  parameter int OUT_W   = 6,
  parameter int LANES   = 4,
  parameter int OUT_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   wr_en,
  input  logic [OUT_W-1:0]       wr_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   table_ready,
  output logic                   load_err
);

  localparam int DEPTH = 1 << IN_W;
  localparam logic [IN_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_READY
  } state_e;

  state_e                   state_q, state_d;
  logic [IN_W-1:0]          cnt_q, cnt_d;
  logic                     mem_we;
  logic [IN_W-1:0]          mem_waddr;
  logic [OUT_W-1:0]         mem [DEPTH];
  logic                     load_err_q;
  logic                     accept;
  logic [LANES*OUT_W-1:0]   rd_data;
  logic                     s1_v_q;
  logic [LANES*OUT_W-1:0]   s1_d_q;

  assign in_ready    = (state_q == S_READY);
  assign table_ready = (state_q == S_READY);
  assign load_err    = load_err_q;
  assign accept      = in_valid & in_ready;

  // Load sequencing: restart has priority and may carry entry 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    unique case (state_q)
      S_EMPTY: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          cnt_d = '0;
          if (wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            cnt_d     = IN_W'(1);
          end
        end else if (wr_en) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + IN_W'(1);
          if (cnt_q == LAST) state_d = S_READY;
        end
      end
      S_READY: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and the write-outside-load error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_err_q <= wr_en && (state_q != S_LOAD);
    end
  end

  // Table storage; contents survive reset and are only trusted after a full load.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wr_data;
  end

  // All lanes index the shared table in parallel.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_data[k*OUT_W +: OUT_W] = mem[in_data[k*IN_W +: IN_W]];
    end
  end

  // Stage-1 result register; data holds when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_d_q <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) s1_d_q <= rd_data;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                   s2_v_q;
    logic [LANES*OUT_W-1:0] s2_d_q;

    // Optional second register stage for timing.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_v_q <= 1'b0;
        s2_d_q <= '0;
      end else begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_d_q <= s1_d_q;
      end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_d_q;
  end else begin : g_noreg
    assign out_valid = s1_v_q;
    assign out_data  = s1_d_q;
  end

endmodule

// File: tb/tb_odo_sbox_bank.sv
// tb_odo_sbox_bank: scoreboard bench driving OUT_REG=1 and OUT_REG=0
// instances with the same stimulus.
module tb_odo_sbox_bank;

  typedef struct packed {
    int          t;
    logic [23:0] d;
  } exp_t;

  localparam int S_EMPTY = 0;
  localparam int S_LOAD  = 1;
  localparam int S_READY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        wr_en;
  logic [5:0]  wr_data;
  logic        in_valid;
  logic [23:0] in_data;

  logic        ir1, ov1, tr1, le1;
  logic [23:0] od1;
  logic        ir0, ov0, tr0, le0;
  logic [23:0] od0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exp_t q1[$];
  exp_t q0[$];

  int         mst;
  int         mcnt;
  logic [5:0] mtab [64];

  odo_sbox_bank #(.IN_W(6), .OUT_W(6), .LANES(4), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .load_start(load_start), .wr_en(wr_en),
    .wr_data(wr_data), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_data(od1),
    .table_ready(tr1), .load_err(le1)
  );

  odo_sbox_bank #(.IN_W(6), .OUT_W(6), .LANES(4), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .load_start(load_start), .wr_en(wr_en),
    .wr_data(wr_data), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_data(od0),
    .table_ready(tr0), .load_err(le0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] pack4(input logic [5:0] l0,
      input logic [5:0] l1, input logic [5:0] l2, input logic [5:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor for the two-cycle-latency instance.
  always @(negedge clk) begin
    exp_t e;
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("r1_unexpected_valid", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("r1_latency", cyc, e.t);
        chk("r1_data", {8'h0, od1}, {8'h0, e.d});
      end
    end
  end

  // Monitor for the one-cycle-latency instance.
  always @(negedge clk) begin
    exp_t e;
    if (ov0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("r0_unexpected_valid", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("r0_latency", cyc, e.t);
        chk("r0_data", {8'h0, od0}, {8'h0, e.d});
      end
    end
  end

  // One clock of stimulus; called at posedge+#1.
  task automatic step(input bit ls, input bit we, input logic [5:0] wd,
                      input bit iv, input logic [23:0] id,
                      input bit hx, input logic [23:0] hv);
    exp_t e;
    bit   merr;
    load_start = ls;
    wr_en      = we;
    wr_data    = wd;
    in_valid   = iv;
    in_data    = id;
    chk("in_ready1", ir1, (mst == S_READY));
    chk("in_ready0", ir0, (mst == S_READY));
    if (iv && mst == S_READY) begin
      if (hx) begin
        e.d = hv;
      end else begin
        e.d = pack4(mtab[id[5:0]], mtab[id[11:6]],
                    mtab[id[17:12]], mtab[id[23:18]]);
      end
      e.t = cyc + 2;
      q1.push_back(e);
      e.t = cyc + 1;
      q0.push_back(e);
    end
    merr = we && (mst != S_LOAD);
    if (mst == S_LOAD) begin
      if (ls) begin
        mcnt = 0;
        if (we) begin
          mtab[0] = wd;
          mcnt    = 1;
        end
      end else if (we) begin
        mtab[mcnt] = wd;
        if (mcnt == 63) begin
          mst  = S_READY;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end else if (ls) begin
      mst  = S_LOAD;
      mcnt = 0;
    end
    @(posedge clk);
    #1;
    chk("table_ready1", tr1, (mst == S_READY));
    chk("table_ready0", tr0, (mst == S_READY));
    chk("load_err1", le1, merr);
    chk("load_err0", le0, merr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 6'h0, 0, 24'h0, 0, 24'h0);
  endtask

  task automatic lookup(input logic [23:0] id, input logic [23:0] hv);
    step(0, 0, 6'h0, 1, id, 1, hv);
  endtask

  task automatic full_load(input bit with_iv);
    step(1, 0, 6'h0, 0, 24'h0, 0, 24'h0);
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 6'(i) ^ 6'h2A, with_iv && (i < 4), 24'hFFFFFF, 0, 24'h0);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_start = 1'b0;
    wr_en      = 1'b0;
    in_valid   = 1'b0;
    @(posedge clk);
    #1;
    q1.delete();
    q0.delete();
    rst  = 1'b0;
    mst  = S_EMPTY;
    mcnt = 0;
    chk("rst_out_valid1", ov1, 0);
    chk("rst_out_valid0", ov0, 0);
    chk("rst_out_data1", {8'h0, od1}, 0);
    chk("rst_out_data0", {8'h0, od0}, 0);
    chk("rst_table_ready1", tr1, 0);
    chk("rst_table_ready0", tr0, 0);
    chk("rst_in_ready1", ir1, 0);
    chk("rst_in_ready0", ir0, 0);
    chk("rst_load_err1", le1, 0);
    chk("rst_load_err0", le0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    mst        = S_EMPTY;
    mcnt       = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // in_valid while EMPTY is dropped
    step(0, 0, 6'h0, 1, pack4(6'd1, 6'd2, 6'd3, 6'd4), 0, 24'h0);
    step(0, 0, 6'h0, 1, pack4(6'd5, 6'd6, 6'd7, 6'd8), 0, 24'h0);

    // load i ^ 2A, with in_valid during LOAD
    full_load(1);

    // lanes {63,0,21,5}
    lookup(pack4(6'd63, 6'd0, 6'd21, 6'd5),
           pack4(6'h15, 6'h2A, 6'h3F, 6'h2F));
    idle(3);

    // back-to-back accepts
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 6'h0, 1, 24'($urandom), 0, 24'h0);
    end
    idle(3);

    // wr_en in READY: error pulse, table unchanged
    step(0, 1, 6'h3F, 0, 24'h0, 0, 24'h0);
    lookup(pack4(6'd3, 6'd3, 6'd3, 6'd3),
           pack4(6'h29, 6'h29, 6'h29, 6'h29));
    idle(3);

    // restart with write after 40 entries
    step(1, 0, 6'h0, 0, 24'h0, 0, 24'h0);
    for (int i = 0; i < 40; i++) step(0, 1, 6'(i) ^ 6'h2A, 0, 24'h0, 0, 24'h0);
    step(1, 1, 6'h11, 0, 24'h0, 0, 24'h0);
    for (int i = 1; i < 64; i++) step(0, 1, 6'(i) ^ 6'h2A, 0, 24'h0, 0, 24'h0);
    lookup(pack4(6'd0, 6'd0, 6'd2, 6'd0),
           pack4(6'h11, 6'h11, 6'h28, 6'h11));
    idle(3);

    // accept together with load_start uses old table
    step(1, 0, 6'h0, 1, pack4(6'd1, 6'd1, 6'd1, 6'd1), 1,
         pack4(6'h2B, 6'h2B, 6'h2B, 6'h2B));
    for (int i = 0; i < 64; i++) step(0, 1, 6'(i) ^ 6'h2A, 0, 24'h0, 0, 24'h0);
    lookup(pack4(6'd0, 6'd1, 6'd2, 6'd3),
           pack4(6'h2A, 6'h2B, 6'h28, 6'h29));
    idle(3);

    // reset with a result in flight
    lookup(pack4(6'd3, 6'd3, 6'd3, 6'd3),
           pack4(6'h29, 6'h29, 6'h29, 6'h29));
    do_reset();
    step(0, 0, 6'h0, 1, pack4(6'd3, 6'd3, 6'd3, 6'd3), 0, 24'h0);

    // reset mid-load
    step(1, 0, 6'h0, 0, 24'h0, 0, 24'h0);
    for (int i = 0; i < 20; i++) step(0, 1, 6'(i) ^ 6'h2A, 0, 24'h0, 0, 24'h0);
    do_reset();
    step(0, 0, 6'h0, 1, pack4(6'd3, 6'd3, 6'd3, 6'd3), 0, 24'h0);
    idle(2);

    full_load(0);
    lookup(pack4(6'd21, 6'd63, 6'd0, 6'd5),
           pack4(6'h3F, 6'h15, 6'h2A, 6'h2F));
    idle(4);

    chk("q1_drained", q1.size(), 0);
    chk("q0_drained", q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
